// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } seq_mult_state_e;

  // Width needed to hold an iteration count of 0..width inclusive.
  function automatic int calc_cw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_absval.sv
// Conditional two's-complement negate: result = negate ? -value : value.
module seq_mult_absval #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/seq_multiplier.sv
// Parametrised shift-add multiplier with start/busy/done handshake and signed mode.
// Optional macro EARLY_TERM_EN ends the RUN phase once the remaining multiplier bits are zero.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = calc_cw(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        iter_count
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("seq_multiplier: WIDTH must be in 2..32");
  end

  seq_mult_state_e  state_reg;
  logic             sign_reg;
  logic [PW-1:0]    mcand_sh_reg;
  logic [WIDTH-1:0] mplr_sh_reg;
  logic [PW-1:0]    acc_reg;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    acc_fixed;
  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] mplr_shifted;
  logic [CW-1:0]    iter_inc;
  logic             run_last;

  assign a_neg = is_signed & multiplicand[WIDTH-1];
  assign b_neg = is_signed & multiplier[WIDTH-1];

  // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  seq_mult_absval #(.WIDTH(WIDTH)) u_abs_a (
    .value  (multiplicand),
    .negate (a_neg),
    .result (a_mag)
  );

  seq_mult_absval #(.WIDTH(WIDTH)) u_abs_b (
    .value  (multiplier),
    .negate (b_neg),
    .result (b_mag)
  );

  seq_mult_absval #(.WIDTH(PW)) u_fixup (
    .value  (acc_reg),
    .negate (sign_reg),
    .result (acc_fixed)
  );

  assign acc_sum      = acc_reg + (mplr_sh_reg[0] ? mcand_sh_reg : '0);
  assign mplr_shifted = mplr_sh_reg >> 1;
  assign iter_inc     = iter_count + CW'(1);

`ifdef EARLY_TERM_EN
  assign run_last = (iter_inc == LAST_ITER) || (mplr_shifted == '0);
`else
  assign run_last = (iter_inc == LAST_ITER);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sign_reg     <= 1'b0;
      mcand_sh_reg <= '0;
      mplr_sh_reg  <= '0;
      acc_reg      <= '0;
      iter_count   <= '0;
      product      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            sign_reg     <= a_neg ^ b_neg;
            mcand_sh_reg <= {{WIDTH{1'b0}}, a_mag};
            mplr_sh_reg  <= b_mag;
            acc_reg      <= '0;
            iter_count   <= '0;
            busy         <= 1'b1;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          acc_reg      <= acc_sum;
          mcand_sh_reg <= mcand_sh_reg << 1;
          mplr_sh_reg  <= mplr_shifted;
          iter_count   <= iter_inc;
          if (run_last) begin
            state_reg <= FIXUP;
          end
        end
        FIXUP: begin
          product   <= acc_fixed;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed plus randomized bench for seq_multiplier (WIDTH=4) against an arithmetic reference model.
module tb_seq_multiplier;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          is_signed = 1'b0;
  logic [W-1:0]  multiplicand = '0;
  logic [W-1:0]  multiplier = '0;
  logic [2*W-1:0] product;
  logic          busy;
  logic          done;
  logic [CW-1:0] iter_count;

  int total_checks = 0;
  int failed_checks = 0;
  logic [2*W-1:0] prev_product = '0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done),
    .iter_count   (iter_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    total_checks++;
    assert (obs === exp) else begin
      failed_checks++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer multiply, truncated to 2*W bits.
  function automatic logic [2*W-1:0] ref_product(input logic sgn, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    longint p;
    sa = a;
    sb = b;
    if (sgn) p = longint'(sa) * longint'(sb);
    else     p = longint'(a) * longint'(b);
    return (2*W)'(p);
  endfunction

  // Reference iteration count: WIDTH, or position of highest set bit of |B| with early exit.
  function automatic int ref_iters(input logic sgn, input logic [W-1:0] b);
    int mag;
    int k;
    mag = (sgn && b[W-1]) ? ((1 << W) - int'(b)) : int'(b);
    k = W;
`ifdef EARLY_TERM_EN
    k = 1;
    for (int i = 0; i < W; i++) if (((mag >> i) & 1) == 1) k = i + 1;
`endif
    return k;
  endfunction

  // Called just after a clock edge; returns just after the done edge.
  task automatic do_op(input string tag, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int poke_at);
    logic [2*W-1:0] exp_p;
    int k;
    int cyc;
    exp_p = ref_product(sgn, a, b);
    k = ref_iters(sgn, b);
    start = 1'b1;
    is_signed = sgn;
    multiplicand = a;
    multiplier = b;
    @(posedge clk); #1;
    start = 1'b0;
    multiplicand = W'($urandom);
    multiplier = W'($urandom);
    is_signed = 1'($urandom);
    cyc = 0;
    while (done !== 1'b1 && cyc <= 40) begin
      check({tag, ".busy"}, longint'(busy), 1);
      check({tag, ".hold"}, longint'(product), longint'(prev_product));
      if (cyc == poke_at) begin
        start = 1'b1;
        multiplicand = W'($urandom);
        multiplier = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, ".latency"}, cyc, k + 1);
    check({tag, ".busy_low"}, longint'(busy), 0);
    check({tag, ".product"}, longint'(product), longint'(exp_p));
    check({tag, ".iter"}, longint'(iter_count), k);
    $display("op %s: signed=%0b a=%0h b=%0h product=%0h iter=%0d latency=%0d", tag, sgn, a, b,
             product, iter_count, cyc);
    prev_product = exp_p;
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, longint'(done), 0);
    check({tag, ".idle_hold"}, longint'(product), longint'(prev_product));
  endtask

  initial begin
    logic seen_done;
    logic s;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    #1 rst_n = 1'b0;
    #2;
    check("reset.product", longint'(product), 0);
    check("reset.busy", longint'(busy), 0);
    check("reset.done", longint'(done), 0);
    check("reset.iter", longint'(iter_count), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("legacy_3x2", 1'b0, 4'd3, 4'd2, -1);
    idle_check("legacy_3x2");
    do_op("s_m3x5", 1'b1, 4'b1101, 4'b0101, -1);
    idle_check("s_m3x5");
    do_op("u_13x5", 1'b0, 4'b1101, 4'b0101, -1);
    idle_check("u_13x5");
    do_op("s_m8xm8", 1'b1, 4'b1000, 4'b1000, -1);
    idle_check("s_m8xm8");
    do_op("u_15x15", 1'b0, 4'hF, 4'hF, -1);
    idle_check("u_15x15");
    do_op("s_m8x7", 1'b1, 4'b1000, 4'b0111, -1);
    idle_check("s_m8x7");
    do_op("b_zero", 1'b0, 4'd9, 4'd0, -1);
    idle_check("b_zero");

    do_op("mid_start", 1'b0, 4'd5, 4'd7, 2);
    idle_check("mid_start");

    do_op("b2b_first", 1'b1, 4'd6, 4'b1011, -1);
    do_op("b2b_second", 1'b0, 4'd11, 4'd13, -1);
    idle_check("b2b_second");

    // Abort mid-operation: no done may ever appear for it.
    start = 1'b1;
    is_signed = 1'b0;
    multiplicand = 4'd9;
    multiplier = 4'd11;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort.product", longint'(product), 0);
    check("abort.busy", longint'(busy), 0);
    check("abort.done", longint'(done), 0);
    check("abort.iter", longint'(iter_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    prev_product = '0;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    check("abort.no_done", longint'(seen_done), 0);
    do_op("after_abort_2x3", 1'b0, 4'd2, 4'd3, -1);
    idle_check("after_abort_2x3");

    for (int n = 0; n < 40; n++) begin
      s  = 1'($urandom);
      ra = W'($urandom);
      rb = W'($urandom);
      do_op($sformatf("rand%0d", n), s, ra, rb, ($urandom_range(0, 3) == 0) ? 1 : -1);
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rand%0d", n));
    end
    idle_check("final");

    $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

endmodule
